// File: rtl/divider_gen.sv
// Iterative non-restoring divider with an optional fixed-point (dividend << FRAC) numerator.
// Define DIVIDER_GEN_SIGNED_EN to build two's-complement support selected by signed_op.
module divider_gen #(
    parameter int WIDTH = 32,
    parameter int STEPS = 2,
    parameter int FRAC  = 16
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             offset,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);
    localparam int N  = WIDTH / STEPS;
    localparam int NW = 2 * WIDTH;
    // The shifted numerator spans 2*WIDTH bits, so each cycle consumes 2*STEPS numerator
    // bits; the high quotient bits are discarded but the remainder stays exact.
    localparam int K  = 2 * STEPS;
    localparam int RW = WIDTH + 2;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic                 busy_reg, done_reg, div_zero_reg, zero_reg;
    logic [CW-1:0]        cnt_reg;
    logic [NW-1:0]        num_reg;
    logic [WIDTH-1:0]     quo_reg, div_reg, raw_reg;
    logic signed [RW-1:0] rem_reg;
    logic [WIDTH-1:0]     quotient_reg, remainder_reg;
`ifdef DIVIDER_GEN_SIGNED_EN
    logic                 neg_q_reg, neg_r_reg;
`endif

    logic [WIDTH-1:0]     a_mag, b_mag, raw_init;
    logic [NW-1:0]        num_init;
    logic signed [RW-1:0] div_ext;
    logic signed [RW-1:0] stage_r [0:K];
    logic [K-1:0]         q_step;
    logic [WIDTH+K-1:0]   quo_cat;
    logic [WIDTH-1:0]     quo_next, rmag, q_final, r_final;
    logic signed [RW-1:0] rem_last;
    logic                 unused_sink;

    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
`ifdef DIVIDER_GEN_SIGNED_EN
        if (signed_op && dividend[WIDTH-1]) a_mag = -dividend;
        if (signed_op && divisor[WIDTH-1])  b_mag = -divisor;
`endif
        num_init = {{WIDTH{1'b0}}, a_mag};
        if (offset) num_init = num_init << FRAC;
        raw_init = offset ? (dividend << FRAC) : dividend;
    end

    assign div_ext    = {2'b00, div_reg};
    assign stage_r[0] = rem_reg;

    // Quotient bit is the sign of the trial remainder, identical to the restoring result.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_stage
            logic signed [RW-1:0] trial;
            assign trial          = {stage_r[gi][RW-2:0], num_reg[NW-1-gi]};
            assign stage_r[gi+1]  = stage_r[gi][RW-1] ? trial + div_ext : trial - div_ext;
            assign q_step[K-1-gi] = ~stage_r[gi+1][RW-1];
        end
    endgenerate

    assign quo_cat  = {quo_reg, q_step};
    assign quo_next = quo_cat[WIDTH-1:0];
    assign rem_last = stage_r[K];
    assign rmag     = rem_last[RW-1] ? rem_last[WIDTH-1:0] + div_reg : rem_last[WIDTH-1:0];
    assign unused_sink = ^{rem_last[WIDTH], quo_cat[WIDTH+K-1:WIDTH], signed_op};

    always_comb begin
        q_final = quo_next;
        r_final = rmag;
`ifdef DIVIDER_GEN_SIGNED_EN
        if (neg_q_reg) q_final = -quo_next;
        if (neg_r_reg) r_final = -rmag;
`endif
        if (zero_reg) begin
            q_final = '1;
            r_final = raw_reg;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
            zero_reg      <= 1'b0;
            cnt_reg       <= '0;
            num_reg       <= '0;
            quo_reg       <= '0;
            div_reg       <= '0;
            raw_reg       <= '0;
            rem_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
`ifdef DIVIDER_GEN_SIGNED_EN
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (!busy_reg) begin
                if (start) begin
                    busy_reg <= 1'b1;
                    cnt_reg  <= '0;
                    num_reg  <= num_init;
                    quo_reg  <= '0;
                    rem_reg  <= '0;
                    div_reg  <= b_mag;
                    zero_reg <= (divisor == '0);
                    raw_reg  <= raw_init;
`ifdef DIVIDER_GEN_SIGNED_EN
                    neg_q_reg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_r_reg <= signed_op & dividend[WIDTH-1];
`endif
                end
            end else begin
                num_reg <= num_reg << K;
                quo_reg <= quo_next;
                rem_reg <= rem_last;
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CW'(N - 1)) begin
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b1;
                    quotient_reg  <= q_final;
                    remainder_reg <= r_final;
                    div_zero_reg  <= zero_reg;
                end
            end
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign div_zero  = div_zero_reg;
endmodule

// File: tb/tb_divider_gen.sv
// Directed bench for divider_gen (WIDTH=32, STEPS=2, FRAC=16): vector table plus
// hand-written busy-start, back-to-back and mid-operation reset sequences.
module tb_divider_gen;
    localparam int W = 32;
    localparam int LAT = 16;

    logic         sys_clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0, offset = 1'b0, signed_op = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_zero;
    logic [W-1:0] quotient, remainder;

    int n_checks = 0;
    int n_pass   = 0;

    divider_gen #(.WIDTH(32), .STEPS(2), .FRAC(16)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .start(start), .offset(offset),
        .signed_op(signed_op), .dividend(dividend), .divisor(divisor), .busy(busy),
        .done(done), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         off;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for done; lat = edges from accept to done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic off,
                          input logic sgn, output int lat);
        dividend = a; divisor = b; offset = off; signed_op = sgn; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int c;
        int n_done;
        logic [W-1:0] q_first;

        vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         32'd2,        1'b0};
        vecs[1]  = '{32'd1,          32'd2,          1'b1, 1'b0, 32'h0000_8000,  32'd0,        1'b0};
        vecs[2]  = '{32'h1234,       32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  32'h1234,     1'b1};
        vecs[3]  = '{32'd9,          32'd3,          1'b0, 1'b0, 32'd3,          32'd0,        1'b0};
        vecs[4]  = '{32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 32'hFFFF_FFFF,  32'd0,        1'b0};
        vecs[5]  = '{32'd5,          32'd10,         1'b0, 1'b0, 32'd0,          32'd5,        1'b0};
        vecs[6]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'd1,          32'd0,        1'b0};
        vecs[7]  = '{32'h1234_5678,  32'd7,          1'b1, 1'b0, 32'hC335_B6DB,  32'd3,        1'b0};
        vecs[8]  = '{32'd100,        32'd7,          1'b1, 1'b0, 32'h000E_4924,  32'd4,        1'b0};
`ifdef DIVIDER_GEN_SIGNED_EN
        vecs[9]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'h8000_0000,  32'd0,        1'b0};
`else
        vecs[9]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b1, 32'h7FFF_FFFC,  32'd1,        1'b0};
        vecs[10] = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'd0,          32'h8000_0000, 1'b0};
`endif
        vecs[11] = '{32'h1234,       32'd0,          1'b0, 1'b1, 32'hFFFF_FFFF,  32'h1234,     1'b1};

        // Reset state
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].sgn, lat);
            $display("vec %0d: 0x%08h / 0x%08h off=%0d sgn=%0d -> q=0x%08h r=0x%08h z=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].sgn, quotient, remainder, div_zero, lat);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
            chk($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
            chk($sformatf("vec%0d_div_zero", i), {31'd0, div_zero}, {31'd0, vecs[i].z});
            tick();
            chk($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Starts while busy are ignored; a start in the done cycle is accepted.
        dividend = 32'd100; divisor = 32'd7; offset = 1'b0; signed_op = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        c = 0; n_done = 0;
        while (c < 40 && !(done && c >= LAT)) begin
            tick();
            c++;
            if (done) n_done++;
            start = (c == 3 || c == 8);
            if (start) begin
                dividend = 32'd9; divisor = 32'd3; offset = 1'b1;
            end
        end
        $display("busy-start seq: first done after %0d edges q=0x%08h r=0x%08h", c, quotient, remainder);
        chk("ignored_start_latency", c, LAT);
        chk("ignored_start_done_count", n_done, 1);
        chk("ignored_start_quotient", quotient, 32'd14);
        chk("ignored_start_remainder", remainder, 32'd2);
        q_first = quotient;
        dividend = 32'd9; divisor = 32'd3; offset = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        c = 1;
        while (c < 40 && !done) begin
            if (c == 8) chk("hold_quotient_midop", quotient, q_first);
            tick();
            c++;
        end
        $display("back-to-back: second done %0d edges after first q=0x%08h", c, quotient);
        chk("back_to_back_spacing", c, LAT + 1);
        chk("back_to_back_quotient", quotient, 32'd3);

        // Reset during iteration 5 aborts the operation and clears outputs at once.
        dividend = 32'd100; divisor = 32'd0; offset = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_quotient", quotient, 32'd0);
        chk("midreset_remainder", remainder, 32'd0);
        n_done = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) n_done++;
        end
        chk("midreset_no_done", n_done, 0);
        chk("midreset_div_zero", {31'd0, div_zero}, 32'd0);
        reset_n = 1'b1;
        run_op(32'd100, 32'd7, 1'b0, 1'b0, lat);
        $display("after reset: 100/7 -> q=0x%08h r=0x%08h lat=%0d", quotient, remainder, lat);
        chk("post_reset_latency", lat, LAT);
        chk("post_reset_quotient", quotient, 32'd14);
        chk("post_reset_remainder", remainder, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
